// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding,
// word width and the opcode/immediate split of an instruction word.
package instruction_fetch_pkg;

    localparam int WORD_W = 16;
    localparam int OPC_W  = 4;
    localparam int IMM_W  = 12;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } if_state_e;

endpackage

// File: rtl/instruction_fetch_pc_reg.sv
// Program counter register: a redirect load wins over a sequential
// increment; otherwise the value holds.
import instruction_fetch_pkg::*;

module pc_reg #(
    parameter logic [WORD_W-1:0] RESET_PC = 16'h0000,
    parameter int                PC_STEP  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_target,
    input  logic              i_inc,
    output logic [WORD_W-1:0] o_pc
);

    logic [WORD_W-1:0] r_pc;

    // Addition is truncated to the word width, so the top address wraps to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= i_target;
        end else if (i_inc) begin
            r_pc <= r_pc + WORD_W'(PC_STEP);
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/instruction_fetch.sv
// Single-outstanding instruction fetch: requests a word at PC, holds it for
// the downstream stage until consumed, and accepts branch/jump redirects.
import instruction_fetch_pkg::*;

module instruction_fetch #(
    parameter logic [WORD_W-1:0] RESET_PC = 16'h0000,
    parameter int                PC_STEP  = 1
) (
    input  logic              CLK,
    input  logic              RST_n,
    output logic [WORD_W-1:0] mem_addr,
    output logic              mem_req,
    input  logic              mem_ready,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              pc_load,
    input  logic [WORD_W-1:0] pc_target,
    input  logic              stall,
    input  logic              instr_ack,
    output logic [WORD_W-1:0] instr,
    output logic              instr_valid,
    output logic [OPC_W-1:0]  opcode,
    output logic [IMM_W-1:0]  imm12,
    output logic [WORD_W-1:0] instr_pc
);

    if_state_e         r_state;
    if_state_e         w_state_next;
    logic [WORD_W-1:0] r_instr;
    logic [WORD_W-1:0] r_instr_pc;
    logic [WORD_W-1:0] w_pc;
    logic              w_capture;
    logic              w_consume;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_consume    = 1'b0;
        unique case (r_state)
            FETCH: begin
                if (pc_load) begin
                    w_state_next = FETCH;
                end else if (mem_ready) begin
                    w_capture    = 1'b1;
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                w_consume = instr_ack && !stall;
                if (pc_load || w_consume) begin
                    w_state_next = FETCH;
                end
            end
            default: w_state_next = FETCH;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_instr    <= '0;
            r_instr_pc <= '0;
        end else if (w_capture) begin
            r_instr    <= mem_rdata;
            r_instr_pc <= w_pc;
        end
    end

    // A redirect takes priority, so the increment is suppressed when both occur.
    pc_reg #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_reg (
        .clk      (CLK),
        .rst_n    (RST_n),
        .i_load   (pc_load),
        .i_target (pc_target),
        .i_inc    (w_consume && !pc_load),
        .o_pc     (w_pc)
    );

    assign mem_addr    = w_pc;
    assign mem_req     = (r_state == FETCH) && RST_n;
    assign instr_valid = (r_state == HOLD);
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign opcode      = r_instr[WORD_W-1 -: OPC_W];
    assign imm12       = r_instr[IMM_W-1:0];

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: a transaction-level model is
// compared every falling edge, plus directed literal expectations.
module tb_instruction_fetch;

    logic        clk;
    logic        rst_n;
    logic [15:0] mem_addr;
    logic        mem_req;
    logic        mem_ready;
    logic [15:0] mem_rdata;
    logic        pc_load;
    logic [15:0] pc_target;
    logic        stall;
    logic        instr_ack;
    logic [15:0] instr;
    logic        instr_valid;
    logic [3:0]  opcode;
    logic [11:0] imm12;
    logic [15:0] instr_pc;

    int checks;
    int errors;

    // Model state: the fetch address, the held word and whether it is still unconsumed.
    logic [15:0] m_pc;
    logic [15:0] m_instr;
    logic [15:0] m_ipc;
    bit          m_have;

    instruction_fetch #(
        .RESET_PC (16'h0000),
        .PC_STEP  (1)
    ) dut (
        .CLK         (clk),
        .RST_n       (rst_n),
        .mem_addr    (mem_addr),
        .mem_req     (mem_req),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .pc_load     (pc_load),
        .pc_target   (pc_target),
        .stall       (stall),
        .instr_ack   (instr_ack),
        .instr       (instr),
        .instr_valid (instr_valid),
        .opcode      (opcode),
        .imm12       (imm12),
        .instr_pc    (instr_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = 16'h0000; m_instr = 16'h0000; m_ipc = 16'h0000; m_have = 0;
        end else if (pc_load) begin
            m_pc = pc_target; m_have = 0;
        end else if (!m_have) begin
            if (mem_ready) begin
                m_instr = mem_rdata; m_ipc = m_pc; m_have = 1;
            end
        end else if (instr_ack && !stall) begin
            m_pc = m_pc + 16'd1; m_have = 0;
        end
    end

    always @(negedge clk) begin
        chk("model_addr",   mem_addr, m_pc);
        chk("model_req",    {15'd0, mem_req}, {15'd0, rst_n && !m_have});
        chk("model_valid",  {15'd0, instr_valid}, {15'd0, m_have});
        chk("model_instr",  instr, m_instr);
        chk("model_ipc",    instr_pc, m_ipc);
        chk("model_opcode", {12'd0, opcode}, {12'd0, m_instr[15:12]});
        chk("model_imm12",  {4'd0, imm12}, {4'd0, m_instr[11:0]});
    end

    task automatic step(input logic rdy, input logic [15:0] rdata, input logic ld,
                        input logic [15:0] tgt, input logic ack, input logic stl);
        mem_ready = rdy; mem_rdata = rdata; pc_load = ld; pc_target = tgt;
        instr_ack = ack; stall = stl;
        @(negedge clk);
        $display("txn rdy=%0b rdata=%h ld=%0b tgt=%h ack=%0b stall=%0b -> addr=%h req=%0b valid=%0b instr=%h ipc=%h",
                 rdy, rdata, ld, tgt, ack, stl, mem_addr, mem_req, instr_valid, instr, instr_pc);
        #1;
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; mem_ready = 0; mem_rdata = 0; pc_load = 0; pc_target = 0;
        stall = 0; instr_ack = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req",   {15'd0, mem_req}, 16'd0);
        chk("rst_valid", {15'd0, instr_valid}, 16'd0);
        chk("rst_addr",  mem_addr, 16'h0000);

        rst_n = 1'b1; mem_ready = 1; mem_rdata = 16'h1ABC;
        #1;
        chk("first_addr", mem_addr, 16'h0000);
        chk("first_req",  {15'd0, mem_req}, 16'd1);
        step(1, 16'h1ABC, 0, 16'h0, 0, 0);
        chk("first_valid",  {15'd0, instr_valid}, 16'd1);
        chk("first_opcode", {12'd0, opcode}, 16'h0001);
        chk("first_imm12",  {4'd0, imm12}, 16'h0ABC);
        chk("first_ipc",    instr_pc, 16'h0000);

        for (int i = 0; i < 3; i++) begin
            step(0, 16'h0, 0, 16'h0, 1, 1);
            chk("stall_valid", {15'd0, instr_valid}, 16'd1);
        end
        step(0, 16'h0, 0, 16'h0, 1, 0);
        chk("consume_addr", mem_addr, 16'h0001);
        chk("consume_req",  {15'd0, mem_req}, 16'd1);

        step(1, 16'h5555, 1, 16'h0040, 0, 0);
        chk("ldfetch_instr", instr, 16'h1ABC);
        chk("ldfetch_valid", {15'd0, instr_valid}, 16'd0);
        chk("ldfetch_addr",  mem_addr, 16'h0040);

        step(1, 16'h2222, 0, 16'h0, 0, 0);
        chk("fetch40_ipc", instr_pc, 16'h0040);
        step(0, 16'h0, 1, 16'h0100, 1, 0);
        chk("ldhold_addr",  mem_addr, 16'h0100);
        chk("ldhold_valid", {15'd0, instr_valid}, 16'd0);

        step(0, 16'h0, 1, 16'hFFFF, 0, 0);
        step(1, 16'h3333, 0, 16'h0, 0, 0);
        chk("wrap_ipc", instr_pc, 16'hFFFF);
        step(0, 16'h0, 0, 16'h0, 1, 0);
        chk("wrap_addr", mem_addr, 16'h0000);

        step(0, 16'h0, 0, 16'h0, 1, 0);
        chk("ackfetch_valid", {15'd0, instr_valid}, 16'd0);
        chk("ackfetch_addr",  mem_addr, 16'h0000);
        step(0, 16'h0, 0, 16'h0, 0, 0);

        step(1, 16'hF123, 0, 16'h0, 0, 0);
        chk("f123_instr", instr, 16'hF123);
        mem_ready = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_instr", instr, 16'h0000);
        chk("async_valid", {15'd0, instr_valid}, 16'd0);
        chk("async_addr",  mem_addr, 16'h0000);
        chk("async_req",   {15'd0, mem_req}, 16'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 200; i++) begin
            step(1'($urandom_range(0, 1)), 16'($urandom),
                 1'($urandom_range(0, 9) == 0), 16'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter: RESET_PC, 16'h0000, address of the first instruction fetched after reset.
REQ-002 Parameter: PC_STEP, 1, PC increment per instruction (word-addressed 16-bit memory).
REQ-003 CLK  input  1  single system clock; all state updates on its rising edge.
REQ-004 RST_n  input  1  asynchronous, active-low reset.
REQ-005 mem_addr  output  16  instruction memory address; equals PC.
REQ-006 mem_req  output  1  fetch request; high only in state FETCH.
REQ-007 mem_ready  input  1  memory returns mem_rdata valid this cycle.
REQ-008 mem_rdata  input  16  instruction word from memory.
REQ-009 pc_load  input  1  redirect request (branch/jump).
REQ-010 pc_target  input  16  redirect address; sampled when pc_load high.
REQ-011 stall  input  1  downstream hold; blocks consumption of the held instruction.
REQ-012 instr_ack  input  1  downstream consumes the held instruction.
REQ-013 instr  output  16  held instruction register.
REQ-014 instr_valid  output  1  instr holds a valid, unconsumed instruction.
REQ-015 opcode  output  4  instr[15:12].
REQ-016 imm12  output  12  instr[11:0]; feeds the 12-to-16 sign-extension stage unchanged.
REQ-017 instr_pc  output  16  address from which instr was fetched.

Function
REQ-018 The FSM SHALL have two states, FETCH and HOLD; reset state is FETCH.
REQ-019 In FETCH, mem_req SHALL be 1 and mem_addr SHALL equal PC, combinationally from state.
REQ-020 In FETCH with mem_ready=1 and pc_load=0: instr<=mem_rdata, instr_pc<=PC, go HOLD; instr_valid=1 the next cycle (1-cycle latency from mem_ready).
REQ-021 In FETCH with mem_ready=0 and pc_load=0: remain in FETCH; PC, instr and instr_valid unchanged.
REQ-022 In HOLD, instr_valid SHALL be 1 and mem_req 0.
REQ-023 Consumption is the condition instr_ack=1 and stall=0; it SHALL occur only in HOLD.
REQ-024 On consumption: PC<=PC+PC_STEP modulo 2^16 (16'hFFFF wraps to 16'h0000), go FETCH, instr_valid=0 the next cycle.
REQ-025 In HOLD with no consumption, the FSM SHALL remain in HOLD with all registers unchanged.
REQ-026 pc_load=1 in either state SHALL have priority: PC<=pc_target, go FETCH, instr_valid=0 the next cycle.
REQ-027 pc_load=1 coincident with mem_ready=1 in FETCH: mem_rdata discarded, instr unchanged.
REQ-028 pc_load=1 coincident with consumption in HOLD: PC<=pc_target, not PC+PC_STEP.
REQ-029 instr_ack while in FETCH SHALL be ignored.
REQ-030 opcode and imm12 SHALL be pure slices of the instr register, valid whenever instr_valid=1.

Reset
REQ-031 RST_n low SHALL immediately force: state FETCH, PC=RESET_PC, instr=16'h0000, instr_pc=16'h0000, instr_valid=0.
REQ-032 While RST_n is low, mem_req SHALL be 0; the first request is issued in the first cycle after RST_n goes high.
REQ-033 Reset asserted mid-fetch or mid-hold SHALL discard the in-flight or held instruction with no partial update.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding (FETCH=1'b0, HOLD=1'b1), the 16-bit word width, and the 4/12 opcode/immediate split.
REQ-035 PC update logic SHALL be one sub-module, pc_reg: load, increment, hold, async reset to RESET_PC.

Verification
REQ-036 Reset release, mem_ready=1 with mem_rdata=16'h1ABC -> mem_addr=0x0000; next cycle instr_valid=1, opcode=4'h1, imm12=12'hABC, instr_pc=0x0000.
REQ-037 instr_ack=1, stall=1 held for 3 cycles, then stall=0 -> instr_valid stays 1 throughout the stall; after release mem_addr=0x0001 and mem_req=1.
REQ-038 PC=16'hFFFF, fetch then consume -> next mem_addr=16'h0000.
REQ-039 FETCH with mem_ready=1, pc_load=1, pc_target=16'h0040 -> instr unchanged, instr_valid=0, next mem_addr=16'h0040.
REQ-040 HOLD with instr_ack=1 and pc_load=1, pc_target=16'h0100 -> next mem_addr=16'h0100, not PC+1.
REQ-041 RST_n pulsed low in HOLD with instr=16'hF123 -> instr=0, instr_valid=0, PC=0 without waiting for a clock edge.
